// File: rtl/hdb3_pkg.sv
// hdb3_pkg -- definitions shared by the HDB3 encoder and decoder.
//   DEC_LATENCY : decoder pipeline depth, in accepted symbols
//   bipolar_t   : 2-bit line symbol {pos, neg}
//   SYM_*       : the four symbol codes
//   sym_is_mark : 1 for a legal +1 or -1 mark
package hdb3_pkg;

  localparam int DEC_LATENCY = 4;

  typedef logic [1:0] bipolar_t;

  localparam bipolar_t SYM_ZERO = 2'b00;
  localparam bipolar_t SYM_NEG  = 2'b01;
  localparam bipolar_t SYM_POS  = 2'b10;
  localparam bipolar_t SYM_ILL  = 2'b11;

  // A symbol with both rails high is illegal and carries no mark.
  function automatic logic sym_is_mark(input bipolar_t sym);
    return sym[1] ^ sym[0];
  endfunction

endpackage

// File: rtl/hdb3_decoder_if.sv
// hdb3_decoder_if -- bipolar symbol input and decoded bit output of the decoder.
//   in_valid/in_pos/in_neg : symbol stream (driven by the master)
//   out_valid/data_out     : decoded bit stream (driven by the slave)
interface hdb3_decoder_if;
  logic in_valid;
  logic in_pos;
  logic in_neg;
  logic out_valid;
  logic data_out;

  modport master (output in_valid, output in_pos, output in_neg,
                  input out_valid, input data_out);
  modport slave  (input in_valid, input in_pos, input in_neg,
                  output out_valid, output data_out);
endinterface

// File: rtl/hdb3_delay_line.sv
// hdb3_delay_line -- DEC_LATENCY-stage bit shift register (stage 0 newest).
//   clk, reset : clock, synchronous active-high reset
//   shift      : advance one stage and load din into stage 0
//   clr3       : with shift, also zero the stages above stage 0
//   din        : new bit for stage 0
//   dout       : current content of the oldest stage (the bit leaving on shift)
module hdb3_delay_line
  import hdb3_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic shift,
  input  logic clr3,
  input  logic din,
  output logic dout
);

  logic [DEC_LATENCY-1:0] stages;

  // Shift register; a clear wipes the three symbols that preceded din.
  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '0;
    end else if (shift) begin
      if (clr3) begin
        stages <= {{(DEC_LATENCY-1){1'b0}}, din};
      end else begin
        stages <= {stages[DEC_LATENCY-2:0], din};
      end
    end else begin
      stages <= stages;
    end
  end

  assign dout = stages[DEC_LATENCY-1];

endmodule

// File: rtl/hdb3_decoder.sv
// hdb3_decoder -- HDB3 bipolar line decoder.
//   clk, reset : clock, synchronous active-high reset (wins over in_valid)
//   bus        : hdb3_decoder_if.slave (symbols in, decoded bits out)
//   code_err   : one-cycle pulse on a coding violation   (HDB3_DEC_ERR_EN only)
//   err_cnt    : saturating count of code_err pulses      (HDB3_DEC_ERR_EN only)
// A mark with the same polarity as the previous mark is a V: it decodes as 0
// and zeroes the three preceding symbols, removing the B of a B00V group.
// Defining HDB3_DEC_ERR_EN adds the violation detector and counter.
module hdb3_decoder
  import hdb3_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  hdb3_decoder_if.slave bus
`ifdef HDB3_DEC_ERR_EN
  ,
  output logic                 code_err,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  bipolar_t   sym;
  logic       accept;
  logic       mark;
  logic       pol;
  logic       is_v;
  logic       bit_in;
  logic       shift_out;
  logic       last_pol;
  logic       have_mark;
  logic [2:0] fill;

  // Classify the incoming symbol: mark, polarity and bipolar violation.
  always_comb begin
    sym    = {bus.in_pos, bus.in_neg};
    accept = bus.in_valid;
    mark   = sym_is_mark(sym);
    case (sym)
      SYM_POS: pol = 1'b1;
      SYM_NEG: pol = 1'b0;
      default: pol = 1'b0;
    endcase
    if (accept && mark && have_mark && (pol == last_pol)) begin
      is_v = 1'b1;
    end else begin
      is_v = 1'b0;
    end
    bit_in = mark & ~is_v;
  end

  hdb3_delay_line u_delay (
    .clk   (clk),
    .reset (reset),
    .shift (accept),
    .clr3  (is_v),
    .din   (bit_in),
    .dout  (shift_out)
  );

  // Polarity tracking, fill counter and registered output bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pol      <= 1'b0;
      have_mark     <= 1'b0;
      fill          <= 3'd0;
      bus.out_valid <= 1'b0;
      bus.data_out  <= 1'b0;
    end else if (accept) begin
      if (mark) begin
        last_pol  <= pol;
        have_mark <= 1'b1;
      end
      if (fill != 3'(DEC_LATENCY)) begin
        fill <= fill + 3'd1;
      end
      // Output only once the pipe already holds a full window of symbols.
      bus.out_valid <= (fill == 3'(DEC_LATENCY));
      bus.data_out  <= shift_out;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef HDB3_DEC_ERR_EN
  logic       have_v;
  logic       last_v_pol;
  logic [2:0] zero_run;
  logic       err_now;

  // A violation is an illegal symbol, the fourth zero in a row, or a V with
  // the same polarity as the previous V.
  always_comb begin
    if (accept) begin
      err_now = (sym == SYM_ILL)
              | (~mark & (zero_run == 3'd3))
              | (is_v & have_v & (pol == last_v_pol));
    end else begin
      err_now = 1'b0;
    end
  end

  // Zero-run and V-polarity history, error pulse and saturating counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_v     <= 1'b0;
      last_v_pol <= 1'b0;
      zero_run   <= 3'd0;
      code_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      code_err <= err_now;
      if (err_now && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept) begin
        if (mark) begin
          zero_run <= 3'd0;
        end else if (zero_run != 3'd4) begin
          zero_run <= zero_run + 3'd1;
        end
        if (is_v) begin
          have_v     <= 1'b1;
          last_v_pol <= pol;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_hdb3_decoder.sv
module tb_hdb3_decoder;
  import hdb3_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  hdb3_decoder_if bus ();

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HDB3_DEC_ERR_EN
  logic        code_err;
  logic [15:0] err_cnt;
  logic        code_err2;
  logic [1:0]  err_cnt2;

  hdb3_decoder_if bus2 ();
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_pos   = bus.in_pos;
  assign bus2.in_neg   = bus.in_neg;

  hdb3_decoder #(.ERR_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .code_err(code_err), .err_cnt(err_cnt));
  hdb3_decoder #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .code_err(code_err2), .err_cnt(err_cnt2));
`else
  hdb3_decoder #(.ERR_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  task automatic drive(input bipolar_t s, input logic v);
    bus.in_valid = v;
    bus.in_pos   = s[1];
    bus.in_neg   = s[0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(SYM_ZERO, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(SYM_POS, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%b want v=0 d=0", bus.out_valid, bus.data_out);
    end
`ifdef HDB3_DEC_ERR_EN
    checks++;
    if (code_err !== 1'b0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_err: got err=%b cnt=%0d want 0 0", code_err, err_cnt);
    end
`endif
    reset = 1'b0;
  endtask

  // +,0,0,0,+,-,0,0,0,0 -> 1,0,0,0,0,1 (000V removed)
  task automatic test_000v();
    bipolar_t seq[10] = '{SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_POS,
                          SYM_NEG, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO};
    logic exp_bits[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(seq[i], 1'b1);
      checks++;
      if (bus.out_valid !== (i >= 4)) begin
        errors++;
        $display("FAIL 000v_valid[%0d]: got %b want %b", i, bus.out_valid, (i >= 4));
      end
      if (i >= 4) begin
        checks++;
        if (bus.data_out !== exp_bits[i-4]) begin
          errors++;
          $display("FAIL 000v_data[%0d]: got %b want %b", i - 4, bus.data_out, exp_bits[i-4]);
        end
      end
    end
  endtask

  // +,-,+,0,0,+,0,0,0,0 -> 1,1,0,0,0,0 (B00V removed)
  task automatic test_b00v();
    bipolar_t seq[10] = '{SYM_POS, SYM_NEG, SYM_POS, SYM_ZERO, SYM_ZERO,
                          SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO};
    logic exp_bits[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(seq[i], 1'b1);
      checks++;
      if (bus.out_valid !== (i >= 4)) begin
        errors++;
        $display("FAIL b00v_valid[%0d]: got %b want %b", i, bus.out_valid, (i >= 4));
      end
      if (i >= 4) begin
        checks++;
        if (bus.data_out !== exp_bits[i-4]) begin
          errors++;
          $display("FAIL b00v_data[%0d]: got %b want %b", i - 4, bus.data_out, exp_bits[i-4]);
        end
      end
    end
  endtask

  // Same as 000V stream with an idle cycle (garbage on rails) after each symbol.
  task automatic test_gaps();
    bipolar_t seq[10] = '{SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_POS,
                          SYM_NEG, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO};
    logic exp_bits[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(seq[i], 1'b1);
      checks++;
      if (bus.out_valid !== (i >= 4)) begin
        errors++;
        $display("FAIL gaps_valid[%0d]: got %b want %b", i, bus.out_valid, (i >= 4));
      end
      if (i >= 4) begin
        checks++;
        if (bus.data_out !== exp_bits[i-4]) begin
          errors++;
          $display("FAIL gaps_data[%0d]: got %b want %b", i - 4, bus.data_out, exp_bits[i-4]);
        end
      end
      drive((i % 2 == 0) ? SYM_POS : SYM_NEG, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL gaps_idle[%0d]: got out_valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  // Reset after two symbols; first post-reset mark must not be a V.
  task automatic test_mid_reset();
    bipolar_t seq[5] = '{SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO};
    do_reset();
    drive(SYM_POS, 1'b1);
    drive(SYM_ZERO, 1'b1);
    reset = 1'b1;
    drive(SYM_ZERO, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1);
      checks++;
      if (bus.out_valid !== (i == 4)) begin
        errors++;
        $display("FAIL midrst_valid[%0d]: got %b want %b", i, bus.out_valid, (i == 4));
      end
    end
    checks++;
    if (bus.data_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_data: got %b want 1", bus.data_out);
    end
  endtask

  // V at symbols 6 and 9 (three apart): each clears its own three predecessors.
  task automatic test_back_to_back();
    bipolar_t seq[14] = '{SYM_POS, SYM_NEG, SYM_ZERO, SYM_ZERO, SYM_POS, SYM_POS, SYM_NEG,
                          SYM_ZERO, SYM_NEG, SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO};
    logic exp_bits[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(seq[i], 1'b1);
      if (i >= 4) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== exp_bits[i-4]) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got v=%b d=%b want v=1 d=%b",
                   i - 4, bus.out_valid, bus.data_out, exp_bits[i-4]);
        end
      end
    end
  endtask

  // Illegal symbol decodes as 0 and leaves polarity untouched: +,ILL,- -> 1,0,1
  task automatic test_illegal();
    bipolar_t seq[7] = '{SYM_POS, SYM_ILL, SYM_NEG, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO};
    logic exp_bits[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(seq[i], 1'b1);
      if (i >= 4) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== exp_bits[i-4]) begin
          errors++;
          $display("FAIL illegal_data[%0d]: got v=%b d=%b want v=1 d=%b",
                   i - 4, bus.out_valid, bus.data_out, exp_bits[i-4]);
        end
      end
    end
  endtask

`ifdef HDB3_DEC_ERR_EN
  // ILL,0,0,0,0 -> pulses after symbol 1 and after the fourth zero in a row.
  task automatic test_code_err();
    bipolar_t seq[5] = '{SYM_ILL, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO};
    logic exp_err[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1);
      checks++;
      if (code_err !== exp_err[i]) begin
        errors++;
        $display("FAIL code_err[%0d]: got %b want %b", i, code_err, exp_err[i]);
      end
    end
    checks++;
    if (err_cnt !== 16'd2 || bus.data_out !== 1'b0) begin
      errors++;
      $display("FAIL err_cnt: got cnt=%0d d=%b want cnt=2 d=0", err_cnt, bus.data_out);
    end
  endtask

  // Five illegal symbols into a 2-bit counter saturate at 3.
  task automatic test_err_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(SYM_ILL, 1'b1);
    end
    drive(SYM_ZERO, 1'b0);
    checks++;
    if (err_cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL err_sat: got %0d want 3", err_cnt2);
    end
  endtask
`endif

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pos   = 1'b0;
    bus.in_neg   = 1'b0;
    test_reset();
    test_000v();
    test_b00v();
    test_gaps();
    test_mid_reset();
    test_back_to_back();
    test_illegal();
`ifdef HDB3_DEC_ERR_EN
    test_code_err();
    test_err_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdb3_decoder.md
HDB3_DECODER -- requirements
Module: hdb3_decoder

Interface
REQ-001 Parameter: ERR_CNT_W, 16, width of saturating code-error counter (used only when HDB3_DEC_ERR_EN defined).
REQ-002 Port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  one bipolar symbol presented this cycle.
REQ-005 Port: in_pos  input  1  symbol is +1 mark.
REQ-006 Port: in_neg  input  1  symbol is -1 mark; in_pos=in_neg=0 is a zero symbol.
REQ-007 Port: out_valid  output  1  data_out carries one decoded bit.
REQ-008 Port: data_out  output  1  decoded binary bit (1 = mark).
REQ-009 Port: code_err  output  1  one-cycle pulse, coding violation detected (present only with HDB3_DEC_ERR_EN).
REQ-010 Port: err_cnt  output  ERR_CNT_W  saturating count of code_err pulses (present only with HDB3_DEC_ERR_EN).

Function
REQ-011 Symbol accepted only on cycles with in_valid=1; in_pos/in_neg ignored otherwise; no back-pressure.
REQ-012 Accepted symbol converts to mark bit m = in_pos XOR in_neg; in_pos=in_neg=1 is illegal and SHALL be treated as m=0.
REQ-013 Block SHALL hold last_pol (polarity of most recent mark) and have_mark flag (a mark seen since reset).
REQ-014 Accepted mark with have_mark=1 and polarity equal to last_pol SHALL be classified as V.
REQ-015 First mark after reset SHALL never be classified as V.
REQ-016 Every accepted mark, V included, SHALL update last_pol and set have_mark.
REQ-017 Mark bits SHALL enter a 4-stage shift register (S0 newest..S3 oldest), advancing only on accepted symbols.
REQ-018 On a V, the V bit SHALL enter S0 as 0 and the three older stages holding the preceding three symbols SHALL be cleared in the same cycle, removing B of B00V.
REQ-019 data_out SHALL be the bit shifted out of S3; out_valid SHALL be 1 in the cycle after an accepted symbol once 4 symbols have been accepted since reset.
REQ-020 Latency: bit for accepted symbol k appears with the out_valid following acceptance of symbol k+4; gaps in in_valid stall the pipeline without loss.
REQ-021 Back-to-back V symbols closer than 4 apart SHALL still clear 3 preceding stages each; no state corruption.

Reset
REQ-022 reset=1 at rising clk SHALL clear shift register, fill counter, last_pol, have_mark, out_valid, data_out, code_err, err_cnt to 0.
REQ-023 reset mid-stream SHALL discard all buffered symbols; no out_valid until 4 new symbols accepted.
REQ-024 reset takes priority over in_valid in the same cycle.

Configuration
REQ-025 Macro HDB3_DEC_ERR_EN defined: code_err pulses (cycle after acceptance) on in_pos=in_neg=1, on a fourth consecutive accepted zero, or on two consecutive V of equal polarity; err_cnt increments per pulse, saturating at all-ones.
REQ-026 Macro undefined: code_err, err_cnt and their logic absent; decoding behaviour identical.

Structure
REQ-027 Package hdb3_pkg SHALL hold DEC_LATENCY=4, symbol encoding constants (SYM_ZERO, SYM_POS, SYM_NEG, SYM_ILL) and the shared 2-bit bipolar type used by encoder and decoder.
REQ-028 Sub-module hdb3_delay_line SHALL implement the 4-stage register with shift-enable and 3-stage clear; detection/polarity logic stays in hdb3_decoder.

Verification
REQ-029 After reset, symbols +,0,0,0,+,-,0,0,0,0 (in_valid=1) -> data_out 1,0,0,0,0,1 after 4-symbol latency (000V removed).
REQ-030 After reset, symbols +,-,+,0,0,+,0,0,0,0 -> data_out 1,1,0,0,0,0 (B00V removed, B cleared).
REQ-031 Sequence of REQ-029 with in_valid toggling 1,0 each cycle -> same decoded bits, out_valid only after accepted symbols.
REQ-032 Reset asserted after 2 symbols, then +,0,0,0,0 -> no out_valid before 4th post-reset symbol; first mark not treated as V.
REQ-033 With HDB3_DEC_ERR_EN: symbol in_pos=in_neg=1, then 0,0,0,0 -> two code_err pulses, err_cnt=2, data bits 0.
REQ-034 With HDB3_DEC_ERR_EN, ERR_CNT_W=2: five illegal symbols -> err_cnt stops at 3.
